// File: rtl/sti_pkg.sv
// sti_pkg: shared types and constants for the STI receive path.
//   BYTE_W              byte width
//   FIFO_DEPTH_DEF      default byte FIFO depth
//   fifo_entry_t        FIFO entry: last-byte-of-frame flag plus data byte
//   sti_state_t         packer FSM states (explicit legacy encodings)
package sti_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sti_state_t;

endpackage

// File: rtl/sti_byte_fifo.sv
// sti_byte_fifo: synchronous FIFO of fifo_entry_t with pointer+1-bit occupancy.
//   clk, reset   clock, asynchronous active-high reset
//   push         write push_data (accepted when not full, or when full with a pop)
//   push_data    entry to write
//   pop          consumer request; honoured only when not empty
//   head         entry at the read pointer
//   empty, full  occupancy flags
//   drop         pulse: a push was refused because the FIFO was full
module sti_byte_fifo
    import sti_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        empty,
    output logic        full,
    output logic        drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts the push; an empty FIFO never pops the incoming entry.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sti_byte_packer.sv
// sti_byte_packer: rebuilds STI serial frames into MSB-first bytes and queues
// them with a last-byte flag behind a ready/valid interface.
//   clk, reset   clock, asynchronous active-high reset
//   so_valid     serial qualifier, high for a whole frame
//   so_data      serial bit, bit 7 of each byte first
//   byte_ready   consumer accepts the head byte
//   byte_valid   FIFO not empty
//   byte_data    head byte
//   frame_end    head byte is the last of its frame
//   frame_cnt    frames terminated, wrapping
//   overflow     sticky: byte dropped on full FIFO
//   frame_err    sticky: frame ended with a partial byte
module sti_byte_packer
    import sti_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              so_valid,
    input  logic              so_data,
    input  logic              byte_ready,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_end,
    output logic [7:0]        frame_cnt,
    output logic              overflow,
    output logic              frame_err
);

    sti_state_t        state;
    sti_state_t        state_nxt;
    logic [BYTE_W-1:0] sh;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] pend;
    logic              pend_v;
    logic [BYTE_W-1:0] new_byte;
    logic              byte_done;
    logic              frame_fin;
    logic              push;
    fifo_entry_t       push_data;
    fifo_entry_t       head;
    logic              empty;
    logic              full;
    logic              drop;

    assign new_byte  = {sh[6:0], so_data};
    assign byte_done = so_valid && (bit_cnt == 3'd7);
    // SHIFT is held exactly while the previous so_valid was high, so the
    // state register doubles as the delayed qualifier for edge detection.
    assign frame_fin = (state == SHIFT) && !so_valid;
    // A byte stays pending until the next one completes or the frame ends,
    // which is what lets the last byte carry its flag.
    assign push      = pend_v && (byte_done || frame_fin);
    assign push_data = '{last: frame_fin, data: pend};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (so_valid)  state_nxt = SHIFT;
            SHIFT:   if (frame_fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh        <= '0;
            bit_cnt   <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (so_valid) begin
                sh      <= new_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                pend   <= new_byte;
                pend_v <= 1'b1;
            end
            if (frame_fin) begin
                pend_v    <= 1'b0;
                bit_cnt   <= '0;
                frame_cnt <= frame_cnt + 8'd1;
                if (bit_cnt != 3'd0) begin
                    frame_err <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    sti_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (byte_ready),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .drop      (drop)
    );

    assign byte_valid = !empty;
    assign byte_data  = head.data;
    assign frame_end  = head.last;

endmodule

// File: tb/tb_sti_byte_packer.sv
`timescale 1ns/1ps
// tb_sti_byte_packer: directed frames with a scoreboard queue; a monitor
// compares every accepted output byte against the queued expectation.
module tb_sti_byte_packer;

    logic       clk;
    logic       reset;
    logic       so_valid;
    logic       so_data;
    logic       byte_ready;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_end;
    logic [7:0] frame_cnt;
    logic       overflow;
    logic       frame_err;

    int          n_checks;
    int          n_fail;
    logic [8:0]  exp_q [$];
    longint      pop_times [$];

    sti_byte_packer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .so_valid   (so_valid),
        .so_data    (so_data),
        .byte_ready (byte_ready),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_end  (frame_end),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got last=%0b data=%0h expected none",
                         frame_end, byte_data);
            end else begin
                chk("byte_out", {23'd0, frame_end, byte_data}, {23'd0, exp_q.pop_front()});
            end
            pop_times.push_back($time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        so_valid   = 1'b0;
        so_data    = 1'b0;
        byte_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drive nbits of val MSB-first with so_valid high; leaves so_valid high.
    task automatic send_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            so_valid = 1'b1;
            so_data  = val[i];
            tick();
        end
    endtask

    task automatic end_frame();
        so_valid = 1'b0;
        so_data  = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits);
        send_bits(val, nbits);
        end_frame();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        chk({name, "_valid_low"}, byte_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset values
        reset = 1'b1; so_valid = 1'b0; so_data = 1'b0; byte_ready = 1'b0;
        #1;
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_byte_data",  byte_data,  8'h00);
        chk("rst_frame_end",  frame_end,  1'b0);
        chk("rst_frame_cnt",  frame_cnt,  8'd0);
        chk("rst_overflow",   overflow,   1'b0);
        chk("rst_frame_err",  frame_err,  1'b0);
        do_reset();

        // Single 8-bit frame A5
        byte_ready = 1'b1;
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(32'hA5, 8);
        chk("t1_valid_now",  byte_valid, 1'b1);
        chk("t1_data_now",   byte_data,  8'hA5);
        chk("t1_last_now",   frame_end,  1'b1);
        chk("t1_frame_cnt",  frame_cnt,  8'd1);
        chk("t1_frame_err",  frame_err,  1'b0);
        chk("t1_overflow",   overflow,   1'b0);
        drain("t1");

        // 32-bit frame 12345678
        do_reset();
        byte_ready = 1'b1;
        pop_times.delete();
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        exp_q.push_back({1'b0, 8'h56});
        exp_q.push_back({1'b1, 8'h78});
        send_frame(32'h12345678, 32);
        drain("t2");
        chk("t2_pop_count", pop_times.size(), 4);
        if (pop_times.size() == 4) begin
            chk("t2_gap_12_34", 32'(pop_times[1] - pop_times[0]), 80);
            chk("t2_gap_34_56", 32'(pop_times[2] - pop_times[1]), 80);
            chk("t2_gap_56_78", 32'(pop_times[3] - pop_times[2]), 10);
        end
        chk("t2_frame_cnt", frame_cnt, 8'd1);
        chk("t2_frame_err", frame_err, 1'b0);

        // Overflow: five frames into a depth-4 FIFO with no consumer
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            if (f <= 4) exp_q.push_back({1'b1, 8'(f)});
            send_frame(32'(f), 8);
        end
        chk("t3_overflow",  overflow,   1'b1);
        chk("t3_frame_cnt", frame_cnt,  8'd5);
        chk("t3_valid",     byte_valid, 1'b1);
        chk("t3_head",      byte_data,  8'h01);
        chk("t3_frame_err", frame_err,  1'b0);
        byte_ready = 1'b1;
        drain("t3");
        chk("t3_overflow_sticky", overflow, 1'b1);

        // 12-bit frame ABC: one byte, partial nibble discarded
        do_reset();
        byte_ready = 1'b1;
        exp_q.push_back({1'b1, 8'hAB});
        send_frame(32'hABC, 12);
        chk("t4_frame_err", frame_err, 1'b1);
        chk("t4_frame_cnt", frame_cnt, 8'd1);
        chk("t4_overflow",  overflow,  1'b0);
        drain("t4");

        // Full FIFO with a pop in the push cycle
        do_reset();
        exp_q.push_back({1'b1, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        exp_q.push_back({1'b1, 8'h44});
        exp_q.push_back({1'b1, 8'h55});
        send_frame(32'h11, 8);
        send_frame(32'h22, 8);
        send_frame(32'h33, 8);
        send_frame(32'h44, 8);
        send_bits(32'h55, 8);
        byte_ready = 1'b1;
        end_frame();
        byte_ready = 1'b0;
        chk("t5_overflow", overflow,   1'b0);
        chk("t5_valid",    byte_valid, 1'b1);
        chk("t5_head",     byte_data,  8'h22);
        chk("t5_sb_left",  exp_q.size(), 4);
        byte_ready = 1'b1;
        drain("t5");
        chk("t5_frame_cnt", frame_cnt, 8'd5);
        byte_ready = 1'b0;

        // Asynchronous reset in the middle of a frame
        send_bits(32'h1F, 5);
        so_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("t6_rst_valid",     byte_valid, 1'b0);
        chk("t6_rst_data",      byte_data,  8'h00);
        chk("t6_rst_frame_end", frame_end,  1'b0);
        chk("t6_rst_frame_cnt", frame_cnt,  8'd0);
        chk("t6_rst_overflow",  overflow,   1'b0);
        chk("t6_rst_frame_err", frame_err,  1'b0);
        tick();
        reset = 1'b0;
        tick();
        byte_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(32'h3C, 8);
        chk("t6_frame_err", frame_err, 1'b0);
        chk("t6_frame_cnt", frame_cnt, 8'd1);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
